// File: rtl/nco_slot_scheduler.sv
// nco_slot_scheduler: round-robin (voice, oscillator) slot sequencer for the
// time-multiplexed NCO bank, with per-voice accumulator-zero queuing and a
// single-entry pitch-update holding register released in its target slot.
module nco_slot_scheduler #(
  parameter  int unsigned VOICES  = 8,
  parameter  int unsigned V_OSC   = 4,
  parameter  int unsigned V_WIDTH = 3,
  parameter  int unsigned O_WIDTH = 2,
  parameter  int unsigned DIV     = 4,
  localparam int unsigned PITCH_W = 24
) (
  input  logic               OSC_CLK,
  input  logic               iRST_N,
  input  logic               run,
  output logic               slot_en,
  output logic [V_WIDTH-1:0] vx,
  output logic [O_WIDTH-1:0] ox,
  output logic               frame_start,
  input  logic [VOICES-1:0]  zero_req,
  output logic               accum_zero,
  input  logic               pitch_valid,
  output logic               pitch_ready,
  input  logic [V_WIDTH-1:0] pitch_vx,
  input  logic [O_WIDTH-1:0] pitch_ox,
  input  logic [PITCH_W-1:0] pitch_val,
  output logic               pitch_wr,
  output logic [PITCH_W-1:0] pitch_out,
  output logic               pitch_err
);

  localparam int unsigned DIV_W = $clog2(DIV);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [V_WIDTH-1:0] vx_q, vx_d;
  logic [O_WIDTH-1:0] ox_q, ox_d;
  logic               slot_en_q, slot_en_d;
  logic               frame_q, frame_d;
  logic               az_q, az_d;
  logic               wr_q, wr_d;
  logic               err_q, err_d;
  logic [PITCH_W-1:0] pout_q, pout_d;
  logic [VOICES-1:0]  zpend_q, zpend_d;
  logic               zact_q, zact_d;
  logic               full_q, full_d;
  logic [V_WIDTH-1:0] hvx_q, hvx_d;
  logic [O_WIDTH-1:0] hox_q, hox_d;
  logic [PITCH_W-1:0] hval_q, hval_d;

  logic               strobe_c, adv_c, last_osc_c, last_voice_c;
  logic               hit_c, accept_c, bad_c;
  logic [V_WIDTH-1:0] nvx_c;

  // State register with synchronous active-low reset
  always_ff @(posedge OSC_CLK) begin
    if (!iRST_N) begin
      div_q     <= '0;
      vx_q      <= '0;
      ox_q      <= '0;
      slot_en_q <= 1'b0;
      frame_q   <= 1'b0;
      az_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      pout_q    <= '0;
      zpend_q   <= '0;
      zact_q    <= 1'b0;
      full_q    <= 1'b0;
      hvx_q     <= '0;
      hox_q     <= '0;
      hval_q    <= '0;
    end else begin
      div_q     <= div_d;
      vx_q      <= vx_d;
      ox_q      <= ox_d;
      slot_en_q <= slot_en_d;
      frame_q   <= frame_d;
      az_q      <= az_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      pout_q    <= pout_d;
      zpend_q   <= zpend_d;
      zact_q    <= zact_d;
      full_q    <= full_d;
      hvx_q     <= hvx_d;
      hox_q     <= hox_d;
      hval_q    <= hval_d;
    end
  end

  // Divider, slot walk, zero queue and pitch holding register next-state
  always_comb begin
    div_d     = div_q;
    vx_d      = vx_q;
    ox_d      = ox_q;
    slot_en_d = 1'b0;
    frame_d   = 1'b0;
    az_d      = 1'b0;
    wr_d      = 1'b0;
    err_d     = 1'b0;
    pout_d    = pout_q;
    zpend_d   = zpend_q | zero_req;
    zact_d    = zact_q;
    full_d    = full_q;
    hvx_d     = hvx_q;
    hox_d     = hox_q;
    hval_d    = hval_q;

    // Strobes are registered one edge early so they coincide with div==DIV-1
    strobe_c     = run && (div_q == DIV_W'(DIV - 2));
    adv_c        = run && (div_q == DIV_W'(DIV - 1));
    last_osc_c   = (ox_q == O_WIDTH'(V_OSC - 1));
    last_voice_c = (vx_q == V_WIDTH'(VOICES - 1));
    nvx_c        = last_voice_c ? '0 : vx_q + V_WIDTH'(1);
    hit_c        = full_q && (hvx_q == vx_q) && (hox_q == ox_q);
    accept_c     = pitch_valid && !full_q;
    bad_c        = (32'(pitch_vx) >= VOICES) || (32'(pitch_ox) >= V_OSC);

    if (run) begin
      div_d = adv_c ? '0 : div_q + DIV_W'(1);
    end

    if (adv_c) begin
      if (last_osc_c) begin
        ox_d = '0;
        vx_d = nvx_c;
        // Entering a new voice: arm its zero for the whole visit; a request
        // arriving on this very edge stays pending for the next frame.
        zact_d         = zpend_q[nvx_c];
        zpend_d[nvx_c] = zero_req[nvx_c];
      end else begin
        ox_d = ox_q + O_WIDTH'(1);
      end
    end

    if (strobe_c) begin
      slot_en_d = 1'b1;
      frame_d   = (vx_q == '0) && (ox_q == '0);
      az_d      = zact_q;
      if (hit_c) begin
        wr_d   = 1'b1;
        pout_d = hval_q;
      end
    end

    // Entry frees one cycle after its write strobe
    if (wr_q) begin
      full_d = 1'b0;
    end

    if (accept_c) begin
      if (bad_c) begin
        err_d = 1'b1;
      end else begin
        full_d = 1'b1;
        hvx_d  = pitch_vx;
        hox_d  = pitch_ox;
        hval_d = pitch_val;
      end
    end
  end

  assign slot_en     = slot_en_q;
  assign vx          = vx_q;
  assign ox          = ox_q;
  assign frame_start = frame_q;
  assign accum_zero  = az_q;
  assign pitch_wr    = wr_q;
  assign pitch_out   = pout_q;
  assign pitch_err   = err_q;
  assign pitch_ready = !full_q;

endmodule

// File: doc/nco_slot_scheduler.md
# nco_slot_scheduler

Time-slot sequencer and request scheduler for the shared, time-multiplexed NCO phase-accumulator bank. It walks the (voice, oscillator) slot space round-robin and emits the per-slot strobe and vx/ox indices that drive the NCO. It also queues per-voice accumulator-zero (note-on/hard-sync) requests and a single pitch-update request. Each request is released in the correct slot, so pitch and zero writes never collide with the NCO's own slot sequencing.

## Interface
- VOICES, 8, number of voices
- V_OSC, 4, oscillators per voice
- V_WIDTH, 3, voice index width (2^V_WIDTH ≥ VOICES)
- O_WIDTH, 2, oscillator index width (2^O_WIDTH ≥ V_OSC)
- DIV, 4, OSC_CLK cycles per slot (≥2)

Ports:
- OSC_CLK  in  1  sole clock; all logic on rising edge
- iRST_N  in  1  synchronous active-low reset
- run  in  1  slot sequencing enable
- slot_en  out  1  one-cycle pulse in the last cycle of each slot
- vx  out  V_WIDTH  current slot voice index
- ox  out  O_WIDTH  current slot oscillator index
- frame_start  out  1  pulse coincident with slot_en for slot (0,0)
- zero_req  in  VOICES  per-voice accumulator-zero request, level or pulse, sampled every cycle
- accum_zero  out  1  zero command for current slot, valid with slot_en
- pitch_valid  in  1  pitch-update request valid
- pitch_ready  out  1  holding register empty
- pitch_vx  in  V_WIDTH  target voice
- pitch_ox  in  O_WIDTH  target oscillator
- pitch_val  in  24  new pitch increment
- pitch_wr  out  1  pitch write strobe, valid with slot_en
- pitch_out  out  24  pitch value to write
- pitch_err  out  1  one-cycle pulse: accepted request had out-of-range index and was dropped

## Operation
- Divider: div_cnt counts 0..DIV-1 while run=1. slot_en is registered and high in the cycle where div_cnt==DIV-1.
- Slot order: ox increments fastest 0..V_OSC-1, then vx 0..VOICES-1. Wrap (VOICES-1,V_OSC-1)→(0,0). vx/ox advance in the cycle after slot_en and are stable for a full slot.
- run=0: div_cnt freezes at its current value; slot_en, accum_zero and pitch_wr stay 0; vx/ox hold; pending state is retained. Deasserting run mid-slot resumes the same slot.
- Zero requests: zero_pend[v] is set by zero_req[v]=1.
  - When the slot becomes (v,0), zero_act latches zero_pend[v] and zero_pend[v] clears.
  - If zero_req[v] is high in that same cycle, set wins: pend stays 1 and is serviced next frame.
  - accum_zero = zero_act during slot_en for every slot (v,0..V_OSC-1). zero_act clears on leaving voice v.
  - A request arriving mid-visit to voice v waits for the next frame; a partial voice is never zeroed.
- Pitch holding register (single entry):
  - pitch_ready = !full.
  - On accept (valid && ready), the register captures vx/ox/val.
  - If pitch_vx ≥ VOICES or pitch_ox ≥ V_OSC, the entry is not stored and pitch_err pulses the next cycle.
  - When slot_en fires with the held (vx,ox) equal to the current slot: pitch_wr=1, pitch_out=held value, and full clears. pitch_ready rises the next cycle.
  - pitch_out holds its last value otherwise.
- accum_zero and pitch_wr may assert in the same slot. The consumer applies both; zero takes precedence on the accumulator.

## Timing
- Reset (iRST_N=0 at a clock edge):
  - Outputs: vx=0, ox=0, slot_en=0, frame_start=0, accum_zero=0, pitch_wr=0, pitch_out=0, pitch_err=0.
  - Internal state: div_cnt=0, zero_pend=0, zero_act=0, full=0.
  - Inputs are ignored while reset is asserted. Mid-operation reset discards pending zero and pitch requests.
- First slot_en occurs DIV cycles after reset release with run=1. Frame period is VOICES·V_OSC·DIV cycles.
- Zero latency: from request to accum_zero is at most one frame plus one slot.
- Pitch latency: from accept to pitch_wr is 1 to VOICES·V_OSC·DIV cycles. Back-to-back accepts are spaced by at least one cycle of ready=0 after pitch_wr.
- All outputs are registered; no combinational path from inputs to outputs except pitch_ready (from full).

## Test plan
- Reset release, run=1, defaults: slot_en at cycles 4, 8, 12, …; vx/ox sequence (0,0),(0,1),…,(7,3),(0,0). frame_start every 128 cycles.
- zero_req[3] pulsed during slot (1,2): accum_zero=1 on exactly the 4 slot_en of slots (3,0..3) in the same frame, 0 elsewhere. Pulsed during (3,1): serviced only in the next frame.
- zero_req[5] held high across the (5,0) entry: voice 5 is zeroed this frame and again next frame (set-wins).
- Pitch accept vx=6, ox=2, val=24'h123456 during slot (0,0): pitch_ready=0 until pitch_wr with pitch_out=24'h123456 at the slot_en of (6,2). pitch_ready=1 the next cycle. Out-of-range vx=… with VOICES=6 → pitch_err pulse, ready stays 1.
- run dropped for 10 cycles mid-slot (2,1): no strobes, vx/ox hold, and the slot completes with the remaining div count after run returns.
- iRST_N asserted with zero_pend and a full pitch entry: after release no accum_zero or pitch_wr occurs in the first full frame, and pitch_ready=1.
